cc_mux_scan_controller: RTL and testbench

Round-robin scan controller that sits directly upstream and downstream of the 8-channel, 32-bit datapath multiplexer. It drives the mux selection bus and captures the mux output. It steps through the enabled channels in index order and waits a programmable settle time after each selection change. Each captured word is delivered to the consumer through a valid/ready handshake, tagged with its channel number and a frame-done marker.

---
 rtl/cc_mux_scan_controller.sv | 169 ++++++++++++++++
 tb/tb_cc_mux_scan_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_mux_scan_controller.sv
// Round-robin scan controller for an 8-channel datapath mux: selects enabled
// channels in index order, waits a settle window, then offers each captured word.
module cc_mux_scan_controller #(
  parameter int DATAWIDTH_MUX_SELECTION = 4,
  parameter int DATAWIDTH_BUS           = 32,
  parameter int SETTLE_CYCLES           = 1
) (
  input  logic                               CC_MUXSCAN_CLOCK_50,
  input  logic                               CC_MUXSCAN_RESET_InHigh,
  input  logic                               CC_MUXSCAN_enable_In,
  input  logic [7:0]                         CC_MUXSCAN_channelMask_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]           CC_MUXSCAN_muxData_InBUS,
  input  logic                               CC_MUXSCAN_ready_In,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] CC_MUXSCAN_selection_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]           CC_MUXSCAN_data_OutBUS,
  output logic [2:0]                         CC_MUXSCAN_channel_OutBUS,
  output logic                               CC_MUXSCAN_valid_Out,
  output logic                               CC_MUXSCAN_frameDone_Out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OFFER  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t                             state, state_next;
  logic [DATAWIDTH_MUX_SELECTION-1:0] selection, selection_next;
  logic [DATAWIDTH_BUS-1:0]           data, data_next;
  logic [2:0]                         channel, channel_next;
  logic                               valid, valid_next;
  logic                               frame_done, frame_done_next;
  logic [2:0]                         pointer, pointer_next;
  logic [3:0]                         counter, counter_next;

  logic [2:0] current;
  logic [2:0] pointer_after;
  logic       scan_go;

  // Lowest enabled index >= ptr, wrapping to the lowest enabled index overall.
  function automatic logic [2:0] next_channel(input logic [7:0] mask, input logic [2:0] ptr);
    logic [2:0] res;
    logic       found;
    res   = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= ptr)) begin
        res   = 3'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 7; i >= 0; i--) begin
        if (mask[i]) begin
          res = 3'(i);
        end
      end
    end
    return res;
  endfunction

  function automatic logic any_above(input logic [7:0] mask, input logic [2:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i] && (3'(i) > idx)) begin
        r = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [DATAWIDTH_MUX_SELECTION-1:0] sel_of(input logic [2:0] idx);
    return {{(DATAWIDTH_MUX_SELECTION-3){1'b0}}, idx};
  endfunction

  // The selected channel is always the low bits of the selection register.
  assign current       = selection[2:0];
  assign pointer_after = current + 3'd1;
  assign scan_go       = CC_MUXSCAN_enable_In && (CC_MUXSCAN_channelMask_InBUS != 8'd0);

  // Next-state and next-output logic.
  always_comb begin
    state_next      = state;
    selection_next  = selection;
    data_next       = data;
    channel_next    = channel;
    valid_next      = valid;
    frame_done_next = 1'b0;
    pointer_next    = pointer;
    counter_next    = counter;
    case (state)
      IDLE: begin
        if (scan_go) begin
          selection_next = sel_of(next_channel(CC_MUXSCAN_channelMask_InBUS, pointer));
          counter_next   = 4'd0;
          state_next     = SETTLE;
        end else begin
          state_next = IDLE;
        end
      end
      SETTLE: begin
        counter_next = counter + 4'd1;
        if (counter == SETTLE_LAST) begin
          data_next    = CC_MUXSCAN_muxData_InBUS;
          channel_next = current;
          valid_next   = 1'b1;
          state_next   = OFFER;
        end else begin
          state_next = SETTLE;
        end
      end
      OFFER: begin
        if (CC_MUXSCAN_ready_In) begin
          valid_next      = 1'b0;
          pointer_next    = pointer_after;
          frame_done_next = ~any_above(CC_MUXSCAN_channelMask_InBUS, current);
          if (scan_go) begin
            selection_next = sel_of(next_channel(CC_MUXSCAN_channelMask_InBUS, pointer_after));
            counter_next   = 4'd0;
            state_next     = SETTLE;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = OFFER;
        end
      end
      default: begin
        state_next     = IDLE;
        selection_next = {DATAWIDTH_MUX_SELECTION{1'b0}};
        valid_next     = 1'b0;
        counter_next   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset wins over any handshake on the same edge.
  always_ff @(posedge CC_MUXSCAN_CLOCK_50) begin
    if (CC_MUXSCAN_RESET_InHigh) begin
      state      <= IDLE;
      selection  <= {DATAWIDTH_MUX_SELECTION{1'b0}};
      data       <= {DATAWIDTH_BUS{1'b0}};
      channel    <= 3'd0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      pointer    <= 3'd0;
      counter    <= 4'd0;
    end else begin
      state      <= state_next;
      selection  <= selection_next;
      data       <= data_next;
      channel    <= channel_next;
      valid      <= valid_next;
      frame_done <= frame_done_next;
      pointer    <= pointer_next;
      counter    <= counter_next;
    end
  end

  assign CC_MUXSCAN_selection_OutBUS = selection;
  assign CC_MUXSCAN_data_OutBUS      = data;
  assign CC_MUXSCAN_channel_OutBUS   = channel;
  assign CC_MUXSCAN_valid_Out        = valid;
  assign CC_MUXSCAN_frameDone_Out    = frame_done;

endmodule

// File: tb/tb_cc_mux_scan_controller.sv
// Scoreboard bench for cc_mux_scan_controller: a reference scan-order model queues
// expected words, a negedge monitor pops and compares on every handshake.
module tb_cc_mux_scan_controller;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, ready;
  logic [7:0]  mask;
  logic [31:0] mux_data, data;
  logic [3:0]  sel;
  logic [2:0]  channel;
  logic        valid, frame_done;
  logic [31:0] val [8];

  logic        rst4, en4, ready4;
  logic [31:0] mux4, data4;
  logic [3:0]  sel4;
  logic [2:0]  ch4;
  logic        valid4, fd4;

  assign mux_data = val[sel[2:0]];

  cc_mux_scan_controller #(.DATAWIDTH_MUX_SELECTION(4), .DATAWIDTH_BUS(32), .SETTLE_CYCLES(1)) dut (
    .CC_MUXSCAN_CLOCK_50(clk), .CC_MUXSCAN_RESET_InHigh(rst), .CC_MUXSCAN_enable_In(enable),
    .CC_MUXSCAN_channelMask_InBUS(mask), .CC_MUXSCAN_muxData_InBUS(mux_data),
    .CC_MUXSCAN_ready_In(ready), .CC_MUXSCAN_selection_OutBUS(sel),
    .CC_MUXSCAN_data_OutBUS(data), .CC_MUXSCAN_channel_OutBUS(channel),
    .CC_MUXSCAN_valid_Out(valid), .CC_MUXSCAN_frameDone_Out(frame_done));

  cc_mux_scan_controller #(.DATAWIDTH_MUX_SELECTION(4), .DATAWIDTH_BUS(32), .SETTLE_CYCLES(4)) dut4 (
    .CC_MUXSCAN_CLOCK_50(clk), .CC_MUXSCAN_RESET_InHigh(rst4), .CC_MUXSCAN_enable_In(en4),
    .CC_MUXSCAN_channelMask_InBUS(8'hFE), .CC_MUXSCAN_muxData_InBUS(mux4),
    .CC_MUXSCAN_ready_In(ready4), .CC_MUXSCAN_selection_OutBUS(sel4),
    .CC_MUXSCAN_data_OutBUS(data4), .CC_MUXSCAN_channel_OutBUS(ch4),
    .CC_MUXSCAN_valid_Out(valid4), .CC_MUXSCAN_frameDone_Out(fd4));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mptr = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [31:0] data;
    logic        fd;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Slow mux for the 4-cycle instance: data is only valid 3 cycles after a selection change.
  int         age4 = 15;
  logic [3:0] last4 = 4'd0;
  always @(negedge clk) begin
    if (sel4 !== last4) begin
      age4  = 0;
      last4 = sel4;
    end else if (age4 < 15) begin
      age4 = age4 + 1;
    end
  end
  assign mux4 = (age4 >= 3) ? (32'hA0 + {28'd0, sel4}) : 32'hBAD0_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_next(input logic [7:0] m, input int p);
    int c;
    for (int k = 0; k < 8; k++) begin
      c = (p + k) % 8;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic last_in_frame(input logic [7:0] m, input int c);
    for (int j = c + 1; j < 8; j++) begin
      if (m[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: frameDone timing, hold-under-backpressure, and word comparison.
  logic        fd_exp = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_data;
  logic [2:0]  hold_ch;
  logic [3:0]  hold_sel;
  always @(negedge clk) begin
    exp_t e;
    check("frame_done", 32'(frame_done), 32'(fd_exp));
    check("sel_range", 32'(sel[3]), 32'd0);
    if (valid) check("sel_matches_channel", 32'(sel[2:0]), 32'(channel));
    if (hold) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_data", data, hold_data);
      check("hold_channel", 32'(channel), 32'(hold_ch));
      check("hold_sel", 32'(sel), 32'(hold_sel));
    end
    fd_exp = 1'b0;
    hold   = 1'b0;
    if (!rst) begin
      if (valid && ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got ch %0d data %h expected no word", channel, data);
        end else begin
          e = q.pop_front();
          check("word_channel", 32'(channel), 32'(e.ch));
          check("word_data", data, e.data);
          fd_exp = e.fd;
        end
      end else if (valid) begin
        hold      = 1'b1;
        hold_data = data;
        hold_ch   = channel;
        hold_sel  = sel;
      end
    end
  end

  // Queue k+1 expected words, then enable until k handshakes are seen and drop enable.
  task automatic run_phase(input logic [7:0] m, input int k, input int prob, input bit check_rate);
    int   hs, budget, last_hs, c;
    exp_t e;
    for (int n = 0; n <= k; n++) begin
      c = model_next(m, mptr);
      e.ch = 3'(c);
      e.data = val[c];
      e.fd = last_in_frame(m, c);
      q.push_back(e);
      mptr = (c + 1) % 8;
    end
    mask   = m;
    enable = 1'b1;
    ready  = ($urandom_range(99) < prob);
    hs = 0; budget = 0; last_hs = -1;
    while (hs < k + 1 && budget < 2000) begin
      @(negedge clk);
      if (valid && ready) begin
        if (check_rate && last_hs >= 0) check("throughput_gap", 32'(cyc - last_hs), 32'd2);
        last_hs = cyc;
        hs++;
      end
      @(posedge clk); #1;
      if (hs >= k) enable = 1'b0;
      ready = ($urandom_range(99) < prob);
      budget++;
    end
    if (budget >= 2000) check("phase_timeout", 32'(hs), 32'(k + 1));
    enable = 1'b0;
    ready  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int b;
    b = 0;
    @(negedge clk);
    while (!valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) check(name, 32'(valid), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   c, words, sel_cyc, b;
    logic [3:0] prev_sel4;
    logic prev_valid4;

    rst = 1'b1; enable = 1'b0; ready = 1'b0; mask = 8'h00;
    rst4 = 1'b1; en4 = 1'b0; ready4 = 1'b1;
    for (int i = 0; i < 8; i++) val[i] = 32'hA0 + 32'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_channel", 32'(channel), 32'd0);
    check("reset_data", data, 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);

    // Basic full-mask scan with wrap, then sparse mask.
    run_phase(8'hFF, 9, 100, 1'b1);
    run_phase(8'b1000_0100, 3, 100, 1'b0);

    // Stop during SETTLE of channel 3: words 0..3 still delivered, then idle.
    run_phase(8'hFF, 3, 100, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("stopped_valid", 32'(valid), 32'd0);
    end
    check("stopped_sel_hold", 32'(sel), 32'd3);

    // Enabled with an empty mask: never offers.
    mask = 8'h00; enable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("mask0_valid", 32'(valid), 32'd0);
    end
    @(posedge clk); #1 enable = 1'b0;

    // Backpressure for 5 cycles with the mux data changing underneath.
    for (int i = 0; i < 8; i++) val[i] = $urandom;
    c = model_next(8'hFF, mptr);
    e.ch = 3'(c); e.data = val[c]; e.fd = last_in_frame(8'hFF, c);
    q.push_back(e);
    mptr = (c + 1) % 8;
    mask = 8'hFF; enable = 1'b1; ready = 1'b0;
    @(posedge clk); #1 enable = 1'b0;
    wait_valid("bp_valid_timeout");
    repeat (5) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) val[i] = $urandom;
    end
    ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    check("bp_accepted_first_edge", 32'(valid), 32'd0);

    // Reset in OFFER on the same edge as ready: word dropped, no frameDone, restart at 0.
    mask = 8'h80; enable = 1'b1; ready = 1'b0;
    @(posedge clk); #1 enable = 1'b0;
    wait_valid("rst_valid_timeout");
    @(posedge clk); #1 ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1 ready = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_channel", 32'(channel), 32'd0);
    check("midrst_data", data, 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    mptr = 0;
    for (int i = 0; i < 8; i++) val[i] = 32'hA0 + 32'(i);
    run_phase(8'hFF, 2, 100, 1'b0);

    // Randomized phases.
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 8; i++) val[i] = $urandom;
      run_phase(8'($urandom_range(255, 1)), $urandom_range(0, 8), $urandom_range(30, 100), 1'b0);
    end

    // Settle timing on the 4-cycle instance with the slow mux.
    @(posedge clk); #1 rst4 = 1'b0; en4 = 1'b1;
    prev_sel4 = sel4; prev_valid4 = valid4;
    sel_cyc = cyc; words = 0; b = 0; mptr = 0;
    while (words < 8 && b < 300) begin
      @(negedge clk);
      if (sel4 !== prev_sel4) sel_cyc = cyc;
      prev_sel4 = sel4;
      if (valid4 && !prev_valid4) begin
        c = model_next(8'hFE, mptr);
        mptr = (c + 1) % 8;
        check("settle_latency", 32'(cyc - sel_cyc), 32'd4);
        check("settle_channel", 32'(ch4), 32'(c));
        check("settle_data", data4, 32'hA0 + 32'(c));
        words++;
      end
      prev_valid4 = valid4;
      b++;
    end
    if (b >= 300) check("settle_timeout", 32'(words), 32'd8);
    en4 = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
